// File: rtl/user_jtag_pkg.sv
// Shared definitions for the BSCAN user-chain registers (capture and update directions).
package user_jtag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } upd_state_t;

  // Function select vector {FUPD, FSH} as seen by every user-chain register.
  localparam int unsigned FSEL_W       = 2;
  localparam int unsigned FSEL_SH_BIT  = 0;
  localparam int unsigned FSEL_UPD_BIT = 1;

  localparam logic [FSEL_W-1:0] FSEL_NONE = 2'b00;
  localparam logic [FSEL_W-1:0] FSEL_SH   = 2'b01;
  localparam logic [FSEL_W-1:0] FSEL_UPD  = 2'b10;

  // Counter wide enough to hold WIDTH+1 so over-length shifts stay distinguishable.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/upd_edge_det.sv
// Registers the TAP Update-DR level and flags its first qualified sampled edge.
module upd_edge_det (
  input  logic DRCK,
  input  logic RST_B,
  input  logic CE,
  input  logic UPDATE,
  output logic UPD_RISE
);

  logic upd_q;

  always_ff @(posedge DRCK or negedge RST_B) begin
    if (!RST_B) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= UPDATE;
    end
  end

  assign UPD_RISE = CE & UPDATE & ~upd_q;

endmodule

// File: rtl/user_upd_reg.sv
// JTAG user data register: shifts TDI in LSB-first and transfers the word to PO on
// Update-DR only when exactly WIDTH bits were shifted since Capture-DR.
import user_jtag_pkg::*;

module user_upd_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             DRCK,
  input  logic             RST_B,
  input  logic             FSH,
  input  logic             FUPD,
  input  logic             SEL,
  input  logic             TDI,
  input  logic             SHIFT,
  input  logic             CAPTURE,
  input  logic             UPDATE,
  output logic [WIDTH-1:0] PO,
  output logic             UPD_STRB,
  output logic             LEN_ERR,
  output logic             TDO
);

  localparam int unsigned   CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic [FSEL_W-1:0] fsel;
  logic              ce;
  logic              cap_en;
  logic              shift_en;
  logic              upd_rise;
  logic [WIDTH-1:0]  sr;
  logic [CW-1:0]     cnt;
  upd_state_t        state;

  assign fsel = {FUPD, FSH};

  always_comb begin
    ce = SEL & ((fsel[FSEL_SH_BIT] & SHIFT) |
                (fsel[FSEL_UPD_BIT] & (CAPTURE | SHIFT | UPDATE)));
    cap_en = ce & CAPTURE;
    // Capture and a new update both pre-empt a coincident shift.
    shift_en = ce & SHIFT & ~CAPTURE & ~upd_rise;
    TDO = ce & sr[0];
  end

  upd_edge_det u_edge (
    .DRCK     (DRCK),
    .RST_B    (RST_B),
    .CE       (ce),
    .UPDATE   (UPDATE),
    .UPD_RISE (upd_rise)
  );

  always_ff @(posedge DRCK or negedge RST_B) begin
    if (!RST_B) begin
      sr  <= '0;
      cnt <= '0;
    end else if (cap_en) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr <= {TDI, sr[WIDTH-1:1]};
      if (cnt != CNT_SAT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge DRCK or negedge RST_B) begin
    if (!RST_B) begin
      state    <= IDLE;
      PO       <= RST_VAL;
      UPD_STRB <= 1'b0;
      LEN_ERR  <= 1'b0;
    end else begin
      UPD_STRB <= 1'b0;
      case (state)
        IDLE: begin
          if (cap_en && fsel[FSEL_UPD_BIT]) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (!cap_en && upd_rise) begin
            if (cnt == CNT_FULL) begin
              PO       <= sr;
              UPD_STRB <= 1'b1;
              LEN_ERR  <= 1'b0;
            end else begin
              LEN_ERR  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_upd_reg.sv
// Directed bench for user_upd_reg with WIDTH=8 and RST_VAL=8'hA5.
module tb_user_upd_reg;

  localparam logic [7:0] RV = 8'hA5;

  logic       DRCK = 1'b0;
  logic       RST_B, FSH, FUPD, SEL, TDI, SHIFT, CAPTURE, UPDATE;
  logic [7:0] PO;
  logic       UPD_STRB, LEN_ERR, TDO;

  int checks = 0;
  int errors = 0;

  user_upd_reg #(.WIDTH(8), .RST_VAL(RV)) dut (
    .DRCK     (DRCK),
    .RST_B    (RST_B),
    .FSH      (FSH),
    .FUPD     (FUPD),
    .SEL      (SEL),
    .TDI      (TDI),
    .SHIFT    (SHIFT),
    .CAPTURE  (CAPTURE),
    .UPDATE   (UPDATE),
    .PO       (PO),
    .UPD_STRB (UPD_STRB),
    .LEN_ERR  (LEN_ERR),
    .TDO      (TDO)
  );

  always #5 DRCK = ~DRCK;

  task automatic cyc();
    @(posedge DRCK);
    #1;
  endtask

  task automatic do_capture();
    CAPTURE = 1'b1;
    cyc();
    CAPTURE = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      SHIFT = 1'b1;
      TDI   = v[i];
      cyc();
    end
    SHIFT = 1'b0;
    TDI   = 1'b0;
  endtask

  task automatic test_reset();
    RST_B = 1'b1; FSH = 1'b0; FUPD = 1'b0; SEL = 1'b0; TDI = 1'b0;
    SHIFT = 1'b0; CAPTURE = 1'b0; UPDATE = 1'b0;
    #3 RST_B = 1'b0;
    #1;
    checks++; if (PO !== RV) begin errors++; $display("FAIL reset_po got %h want %h", PO, RV); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b want 0", LEN_ERR); end
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL reset_strb got %b want 0", UPD_STRB); end
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b want 0", TDO); end
    cyc();
    RST_B = 1'b1;
    cyc();
    cyc();
    checks++; if (PO !== RV) begin errors++; $display("FAIL reset_po_hold got %h want %h", PO, RV); end
  endtask

  task automatic test_good_update();
    int n_strb;
    FSH = 1'b0; FUPD = 1'b1; SEL = 1'b1;
    do_capture();
    shift_bits(16'h003C, 8);
    cyc();
    checks++; if (PO !== RV) begin errors++; $display("FAIL good_po_before got %h want %h", PO, RV); end
    UPDATE = 1'b1;
    n_strb = 0;
    cyc();
    checks++; if (PO !== 8'h3C) begin errors++; $display("FAIL good_po got %h want 3c", PO); end
    checks++; if (UPD_STRB !== 1'b1) begin errors++; $display("FAIL good_strb got %b want 1", UPD_STRB); end
    if (UPD_STRB === 1'b1) n_strb++;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) UPDATE = 1'b0;
      cyc();
      if (UPD_STRB === 1'b1) n_strb++;
    end
    checks++; if (n_strb != 1) begin errors++; $display("FAIL good_strb_count got %0d want 1", n_strb); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL good_len_err got %b want 0", LEN_ERR); end
    checks++; if (PO !== 8'h3C) begin errors++; $display("FAIL good_po_hold got %h want 3c", PO); end
  endtask

  task automatic test_length_err();
    do_capture();
    shift_bits(16'h0055, 7);
    UPDATE = 1'b1;
    cyc();
    UPDATE = 1'b0;
    checks++; if (LEN_ERR !== 1'b1) begin errors++; $display("FAIL short_len_err got %b want 1", LEN_ERR); end
    checks++; if (PO !== 8'h3C) begin errors++; $display("FAIL short_po got %h want 3c", PO); end
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL short_strb got %b want 0", UPD_STRB); end
    cyc();
    do_capture();
    shift_bits(16'h013C, 9);
    UPDATE = 1'b1;
    cyc();
    UPDATE = 1'b0;
    checks++; if (LEN_ERR !== 1'b1) begin errors++; $display("FAIL long_len_err got %b want 1", LEN_ERR); end
    checks++; if (PO !== 8'h3C) begin errors++; $display("FAIL long_po got %h want 3c", PO); end
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL long_strb got %b want 0", UPD_STRB); end
    cyc();
    do_capture();
    shift_bits(16'h0081, 8);
    UPDATE = 1'b1;
    cyc();
    UPDATE = 1'b0;
    checks++; if (PO !== 8'h81) begin errors++; $display("FAIL recover_po got %h want 81", PO); end
    checks++; if (UPD_STRB !== 1'b1) begin errors++; $display("FAIL recover_strb got %b want 1", UPD_STRB); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL recover_len_err got %b want 0", LEN_ERR); end
    cyc();
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL recover_strb_width got %b want 0", UPD_STRB); end
  endtask

  task automatic test_fsh_only();
    logic [15:0] v;
    logic [15:0] got;
    int n_strb;
    v = 16'hBEEF;
    got = '0;
    FSH = 1'b1; FUPD = 1'b0; SEL = 1'b1;
    do_capture();
    for (int k = 0; k < 16; k++) begin
      SHIFT = 1'b1;
      TDI   = v[k];
      #1;
      got[k] = TDO;
      cyc();
    end
    SHIFT = 1'b0; TDI = 1'b0;
    checks++; if (got !== 16'hEF81) begin errors++; $display("FAIL fsh_tdo_stream got %h want ef81", got); end
    n_strb = 0;
    UPDATE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) UPDATE = 1'b0;
      cyc();
      if (UPD_STRB === 1'b1) n_strb++;
    end
    checks++; if (n_strb != 0) begin errors++; $display("FAIL fsh_strb_count got %0d want 0", n_strb); end
    checks++; if (PO !== 8'h81) begin errors++; $display("FAIL fsh_po got %h want 81", PO); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL fsh_len_err got %b want 0", LEN_ERR); end
  endtask

  task automatic test_ignored_update();
    FSH = 1'b0; FUPD = 1'b1; SEL = 1'b1;
    UPDATE = 1'b1;
    cyc();
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL idle_upd_strb got %b want 0", UPD_STRB); end
    cyc();
    UPDATE = 1'b0;
    cyc();
    checks++; if (PO !== 8'h81) begin errors++; $display("FAIL idle_upd_po got %h want 81", PO); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL idle_upd_len_err got %b want 0", LEN_ERR); end
  endtask

  task automatic test_collision();
    logic [7:0] w;
    w = 8'h5A;
    do_capture();
    for (int i = 0; i < 8; i++) begin
      SHIFT = 1'b1;
      TDI   = w[i];
      cyc();
    end
    TDI = 1'b1;
    UPDATE = 1'b1;
    cyc();
    SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
    checks++; if (PO !== 8'h5A) begin errors++; $display("FAIL coll_po got %h want 5a", PO); end
    checks++; if (UPD_STRB !== 1'b1) begin errors++; $display("FAIL coll_strb got %b want 1", UPD_STRB); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL coll_len_err got %b want 0", LEN_ERR); end
    cyc();
    // sr must still hold 5A: a dropped shift leaves bit 0 at 0, a taken one would make it 1.
    SHIFT = 1'b1;
    #1;
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL coll_shift_dropped got %b want 0", TDO); end
    SHIFT = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_shift();
    int n_strb;
    FSH = 1'b0; FUPD = 1'b1; SEL = 1'b1;
    do_capture();
    shift_bits(16'h000F, 4);
    #2 RST_B = 1'b0;
    #1;
    checks++; if (PO !== RV) begin errors++; $display("FAIL midrst_po_async got %h want %h", PO, RV); end
    checks++; if (UPD_STRB !== 1'b0) begin errors++; $display("FAIL midrst_strb got %b want 0", UPD_STRB); end
    cyc();
    RST_B = 1'b1;
    cyc();
    n_strb = 0;
    UPDATE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) UPDATE = 1'b0;
      cyc();
      if (UPD_STRB === 1'b1) n_strb++;
    end
    checks++; if (n_strb != 0) begin errors++; $display("FAIL midrst_strb_count got %0d want 0", n_strb); end
    checks++; if (PO !== RV) begin errors++; $display("FAIL midrst_po got %h want %h", PO, RV); end
    checks++; if (LEN_ERR !== 1'b0) begin errors++; $display("FAIL midrst_idle_len_err got %b want 0", LEN_ERR); end
    SHIFT = 1'b1;
    #1;
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL midrst_sr_cleared got %b want 0", TDO); end
    SHIFT = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_good_update();
    test_length_err();
    test_fsh_only();
    test_ignored_update();
    test_collision();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_upd_reg.md
# user_upd_reg

Serial-in, parallel-out JTAG user data register that sits on the same BSCAN user chain as the team's capture (PISO) registers, in the opposite direction: it loads data from the host into the fabric. TDI is shifted in LSB-first during Shift-DR. On Update-DR the accumulated word is transferred to a held parallel output, but only if exactly `WIDTH` bits were shifted since the last Capture-DR. A length mismatch raises an error flag instead. The block drives DCFEB/ODMB control words written by the host over JTAG.

## Interface
Parameters:
- `WIDTH`, 8, register length in bits (≥2)
- `RST_VAL`, `{WIDTH{1'b0}}`, value of `PO` after reset

Ports:
- `DRCK`  in  1  chain clock; all state changes on rising edge
- `RST_B`  in  1  reset, asynchronous, active-low
- `FSH`  in  1  function select: plain shift-through (no update)
- `FUPD`  in  1  function select: shift + length-checked update
- `SEL`  in  1  user chain selected
- `TDI`  in  1  serial data in
- `SHIFT`  in  1  TAP in Shift-DR
- `CAPTURE`  in  1  TAP in Capture-DR
- `UPDATE`  in  1  TAP in Update-DR (level; sampled on `DRCK`)
- `PO`  out  `WIDTH`  held parallel output (registered)
- `UPD_STRB`  out  1  one-cycle pulse when `PO` is loaded
- `LEN_ERR`  out  1  last update rejected (sticky until next good update or reset)
- `TDO`  out  1  serial data out, gated by `ce`

## Operation
- `ce = SEL & (FSH&SHIFT | FUPD&(CAPTURE|SHIFT|UPDATE))`.
- `TDO = ce & sr[0]` (combinational). This lets the block chain behind other user registers.
- Shift register `sr[WIDTH-1:0]`: on `ce&SHIFT`, `sr <= {TDI, sr[WIDTH-1:1]}`. Otherwise it holds. Capture does not load `sr`.
- Bit counter `cnt`, width `$clog2(WIDTH+2)`:
  - Cleared on `ce&CAPTURE`.
  - Increments on `ce&SHIFT`.
  - Saturates at `WIDTH+1`.
- Update edge `upd_rise = ce & UPDATE & ~upd_q`. `upd_q` is `UPDATE` registered on `DRCK`.
- FSM states:
  - `IDLE`:
    - `FUPD&ce&CAPTURE` → `ARMED`.
    - `UPDATE` is ignored (no strobe, no error change).
  - `ARMED`:
    - On `upd_rise` with `cnt==WIDTH`: `PO<=sr`, `UPD_STRB=1` next cycle, `LEN_ERR<=0`; then → `IDLE`.
    - On `upd_rise` with `cnt!=WIDTH`: `LEN_ERR<=1`, `PO` unchanged, no strobe; then → `IDLE`.
    - Another `ce&CAPTURE`: clears `cnt`, stays in `ARMED`.
    - `SEL` deasserting does not leave `ARMED`.
- FSH-only operation (`FUPD=0`): `sr` shifts and `TDO` is valid. The FSM stays in `IDLE`. `PO` and `LEN_ERR` never change.
- Priority within one cycle: `CAPTURE` > `upd_rise` > `SHIFT`.
  - `upd_rise` coincident with `SHIFT`: the update uses the pre-shift `sr` and `cnt`, and that shift is dropped.
  - `CAPTURE` coincident with `SHIFT`: counter cleared, no shift.

## Timing
- Reset (async assert, sync release on `DRCK`):
  - `sr=0`, `cnt=0`, `upd_q=0`, state `IDLE`.
  - `PO=RST_VAL`, `UPD_STRB=0`, `LEN_ERR=0`.
  - `TDO=0` unless `ce` (`sr[0]=0`).
- Reset mid-shift or in `ARMED` discards the partial word. No strobe is issued.
- `PO` and `UPD_STRB` change on the first `DRCK` edge where `upd_rise` is seen. `UPD_STRB` is high for exactly one `DRCK` cycle.
- `UPDATE` held high for multiple cycles yields a single update. A new update needs `UPDATE` low for ≥1 sampled edge.
- `TDO` follows `sr[0]` combinationally. It updates after each shifting edge, so the first bit out is the `sr[0]` present at Shift-DR entry.

## Structure
- Shared package `user_jtag_pkg`:
  - State enum `upd_state_t {IDLE, ARMED}`.
  - Function `cnt_w(width)` returning `$clog2(width+2)`.
  - Function select codes, so other user-chain registers can reuse them.
- Sub-module `upd_edge_det`: registers `UPDATE` and outputs the `upd_rise` pulse. Everything else is in one module.

## Test plan
- **Reset:** `WIDTH=8`, `RST_VAL=8'hA5`; pulse `RST_B` low mid-clock → `PO=A5`, `LEN_ERR=0`, `UPD_STRB=0` immediately, without waiting for a clock edge.
- **Good update:** `FUPD=1`, `SEL=1`; `CAPTURE`, shift `0x3C` LSB-first (8 bits), `UPDATE` high 3 cycles → `PO=3C` one cycle after the first `UPDATE` edge; one `UPD_STRB` pulse; `LEN_ERR=0`.
- **Short and long shifts:**
  - 7 bits then `UPDATE` → `PO` unchanged, `LEN_ERR=1`, no strobe.
  - Next: `CAPTURE`, 9 bits, `UPDATE` → `LEN_ERR` stays 1.
  - Next: `CAPTURE`, 8 bits `0x81`, `UPDATE` → `PO=81`, `LEN_ERR=0`.
- **FSH only:** `FSH=1`, `FUPD=0`; shift 16 bits of `0xBEEF` → `TDO` replays the first 8 bits delayed by 8 shifts; `UPDATE` → `PO` and `LEN_ERR` unchanged.
- **Ignored update and collisions:**
  - `UPDATE` in `IDLE` with no prior `CAPTURE` → no strobe.
  - `UPDATE` rising in the same cycle as `SHIFT` after 8 bits → update uses the 8-bit word, and the coincident `TDI` bit is not shifted in.
- **Reset mid-shift:** `CAPTURE`, shift 4 bits, assert `RST_B` low, release, then `UPDATE` → no strobe, `PO=RST_VAL`, state `IDLE`.
